// File: rtl/pet_needs_engine.sv
// pet_needs_engine: tracks NCH need levels that decay on a prescaled time base,
// rise on raise requests (with auto-repeat while held), drain faster on demand,
// and summarises overall wellbeing in a four-state FSM.
module pet_needs_engine #(
    parameter int unsigned NCH          = 4,
    parameter int unsigned LVL_W        = 3,
    parameter int unsigned INIT_LVL     = 3,
    parameter int unsigned TICK_DIV     = 100,
    parameter int unsigned ACC_DIV      = 10,
    parameter int unsigned DECAY_TICKS  = 20,
    parameter int unsigned REPEAT_TICKS = 5,
    parameter int unsigned DRAIN_TICKS  = 2,
    parameter int unsigned LOW_TH       = 1,
    parameter int unsigned GRACE_TICKS  = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 acc,
    input  logic [NCH-1:0]       raise,
    input  logic [NCH-1:0]       drain,
    output logic [NCH*LVL_W-1:0] level,
    output logic [NCH-1:0]       low,
    output logic [1:0]           state,
    output logic                 tick
);

    localparam int unsigned MAXL = (1 << LVL_W) - 1;
    localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned NLIM = TICK_DIV - 1;
    localparam int unsigned ALIM = ((TICK_DIV / ACC_DIV) > 0) ? (TICK_DIV / ACC_DIV) - 1 : 0;
    localparam int unsigned DW   = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam int unsigned RW   = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam int unsigned DRW  = (DRAIN_TICKS > 1) ? $clog2(DRAIN_TICKS) : 1;
    localparam int unsigned GW   = (GRACE_TICKS > 1) ? $clog2(GRACE_TICKS) : 1;

    typedef enum logic [1:0] {
        HEALTHY  = 2'b00,
        NEEDY    = 2'b01,
        CRITICAL = 2'b10,
        DEAD     = 2'b11
    } state_e;

    localparam logic [1:0]       RST_ST  = (INIT_LVL == 0)      ? 2'b10 :
                                           (INIT_LVL > LOW_TH)  ? 2'b00 : 2'b01;
    localparam logic [LVL_W-1:0] INIT_V  = LVL_W'(INIT_LVL);
    localparam logic [NCH-1:0]   RST_LOW = (INIT_LVL <= LOW_TH) ? {NCH{1'b1}} : {NCH{1'b0}};

    // Time base
    logic [PW-1:0] pcnt_q;
    logic          tick_q;
    logic [PW-1:0] limit_c;

    // Per-channel state
    logic [NCH-1:0][LVL_W-1:0] level_q, level_d;
    logic [NCH-1:0]            low_q, low_d;
    logic [NCH-1:0][DW-1:0]    dcnt_q, dcnt_d;
    logic [NCH-1:0][RW-1:0]    rcnt_q, rcnt_d;
    logic [NCH-1:0][DRW-1:0]   drcnt_q, drcnt_d;
    logic [NCH-1:0]            raise_q;
    logic [NCH-1:0]            inc_q, inc_d;

    // Per-channel event strobes
    logic [NCH-1:0] rise_c, rep_c, incacc_c, dk_c, dr_c;
    logic           alive_c;
    int             nxt;

    // Wellbeing FSM
    state_e         state_q;
    logic [GW-1:0]  grace_q;
    logic           any_low_c, any_zero_c;

    assign limit_c = acc ? PW'(ALIM) : PW'(NLIM);
    assign alive_c = (state_q != DEAD);

    // Prescaler: strobe one cycle after the counter reaches the active limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else if (pcnt_q >= limit_c) begin
            pcnt_q <= '0;
            tick_q <= 1'b1;
        end else begin
            pcnt_q <= pcnt_q + PW'(1);
            tick_q <= 1'b0;
        end
    end

    // Per-channel counters, event generation and saturating level update
    always_comb begin
        level_d  = level_q;
        low_d    = low_q;
        dcnt_d   = dcnt_q;
        rcnt_d   = rcnt_q;
        drcnt_d  = drcnt_q;
        inc_d    = '0;
        rise_c   = '0;
        rep_c    = '0;
        incacc_c = '0;
        dk_c     = '0;
        dr_c     = '0;
        nxt      = 0;
        for (int i = 0; i < NCH; i++) begin
            rise_c[i]   = raise[i] & ~raise_q[i];
            rep_c[i]    = raise[i] & raise_q[i] & tick_q &
                          (rcnt_q[i] == RW'(REPEAT_TICKS - 1));
            inc_d[i]    = alive_c & (rise_c[i] | rep_c[i]);
            incacc_c[i] = inc_q[i] & alive_c;
            dk_c[i]     = tick_q & (dcnt_q[i] == DW'(DECAY_TICKS - 1));
            dr_c[i]     = drain[i] & tick_q & (drcnt_q[i] == DRW'(DRAIN_TICKS - 1));

            if (!raise[i]) begin
                rcnt_d[i] = '0;
            end else if (raise_q[i] && tick_q) begin
                rcnt_d[i] = rep_c[i] ? '0 : rcnt_q[i] + RW'(1);
            end

            if (dk_c[i] || incacc_c[i]) begin
                dcnt_d[i] = '0;
            end else if (tick_q) begin
                dcnt_d[i] = dcnt_q[i] + DW'(1);
            end

            if (!drain[i]) begin
                drcnt_d[i] = '0;
            end else if (tick_q) begin
                drcnt_d[i] = dr_c[i] ? '0 : drcnt_q[i] + DRW'(1);
            end

            nxt = int'(level_q[i]) + int'(incacc_c[i]) - int'(dk_c[i]) - int'(dr_c[i]);
            if (nxt < 0) begin
                level_d[i] = '0;
            end else if (nxt > int'(MAXL)) begin
                level_d[i] = LVL_W'(MAXL);
            end else begin
                level_d[i] = LVL_W'(nxt);
            end
            low_d[i] = (32'(level_d[i]) <= LOW_TH);
        end
    end

    // Channel register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= {NCH{INIT_V}};
            low_q   <= RST_LOW;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            drcnt_q <= '0;
            raise_q <= '0;
            inc_q   <= '0;
        end else begin
            level_q <= level_d;
            low_q   <= low_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            drcnt_q <= drcnt_d;
            raise_q <= raise;
            inc_q   <= inc_d;
        end
    end

    // Summary flags on the registered levels
    always_comb begin
        any_low_c  = |low_q;
        any_zero_c = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (level_q[i] == '0) any_zero_c = 1'b1;
        end
    end

    // Wellbeing FSM with grace period in CRITICAL; DEAD only leaves on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= state_e'(RST_ST);
            grace_q <= '0;
        end else begin
            case (state_q)
                HEALTHY: begin
                    if (any_low_c) state_q <= NEEDY;
                end
                NEEDY: begin
                    if (any_zero_c)      state_q <= CRITICAL;
                    else if (!any_low_c) state_q <= HEALTHY;
                end
                CRITICAL: begin
                    if (!any_zero_c) begin
                        state_q <= NEEDY;
                        grace_q <= '0;
                    end else if (tick_q) begin
                        if (grace_q == GW'(GRACE_TICKS - 1)) begin
                            state_q <= DEAD;
                            grace_q <= '0;
                        end else begin
                            grace_q <= grace_q + GW'(1);
                        end
                    end
                end
                DEAD: begin
                    state_q <= DEAD;
                end
                default: begin
                    state_q <= state_e'(RST_ST);
                    grace_q <= '0;
                end
            endcase
        end
    end

    assign level = level_q;
    assign low   = low_q;
    assign state = state_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_pet_needs_engine.sv
// tb_pet_needs_engine: vector table with a scoreboard queue, plus hand-written
// sequences for prescaler timing, raise/decay coincidence, grace and reset.
module tb_pet_needs_engine;

    logic        clk;
    logic        rst;
    logic        acc;
    logic [3:0]  raise;
    logic [3:0]  drain;
    logic [11:0] level;
    logic [3:0]  low;
    logic [1:0]  state;
    logic        tick;

    int n_run  = 0;
    int n_fail = 0;
    int ntick  = 0;

    typedef struct {
        bit          do_rst;
        bit          acc;
        logic [3:0]  raise;
        logic [3:0]  drain;
        int          tgt;
        logic [11:0] lvl;
        logic [3:0]  low;
        logic [1:0]  st;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];
    vec_t exp_q [$];

    pet_needs_engine #(
        .NCH(4), .LVL_W(3), .INIT_LVL(3), .TICK_DIV(10), .ACC_DIV(5),
        .DECAY_TICKS(4), .REPEAT_TICKS(3), .DRAIN_TICKS(1), .LOW_TH(1),
        .GRACE_TICKS(8)
    ) dut (
        .clk(clk), .rst(rst), .acc(acc), .raise(raise), .drain(drain),
        .level(level), .low(low), .state(state), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (tick === 1'b1) ntick++;
    endtask

    task automatic do_reset(input bit a, input logic [3:0] r, input logic [3:0] d);
        @(negedge clk);
        acc = a; raise = r; drain = d; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ntick = 0;
    endtask

    // Advance to the k-th tick since reset, then two cycles for level and FSM to settle
    task automatic run_to_tick(input int k);
        int guard;
        guard = 0;
        while (ntick < k && guard < 5000) begin
            step();
            guard++;
        end
        if (ntick < k) begin
            n_run++;
            n_fail++;
            $display("FAIL tick_timeout: got %0d ticks expected %0d", ntick, k);
        end
        step();
        step();
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (tick !== 1'b1 && cycles < 1000);
    endtask

    initial begin
        vec_t v, e;
        int   cyc;

        // Plain decay to DEAD
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 4'h0,  4, 12'h492, 4'h0, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 4'h0, 4'h0,  8, 12'h249, 4'hF, 2'd1};
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 4'h0, 12, 12'h000, 4'hF, 2'd2};
        vecs[3]  = '{1'b0, 1'b0, 4'h0, 4'h0, 19, 12'h000, 4'hF, 2'd2};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 4'h0, 20, 12'h000, 4'hF, 2'd3};
        // Accelerated time base
        vecs[5]  = '{1'b1, 1'b1, 4'h0, 4'h0,  4, 12'h492, 4'h0, 2'd0};
        vecs[6]  = '{1'b0, 1'b1, 4'h0, 4'h0,  8, 12'h249, 4'hF, 2'd1};
        vecs[7]  = '{1'b0, 1'b1, 4'h0, 4'h0, 12, 12'h000, 4'hF, 2'd2};
        // raise[0] held: edge plus auto-repeat, saturating at 7
        vecs[8]  = '{1'b1, 1'b0, 4'h1, 4'h0,  3, 12'h6DD, 4'h0, 2'd0};
        vecs[9]  = '{1'b0, 1'b0, 4'h1, 4'h0,  6, 12'h496, 4'h0, 2'd0};
        vecs[10] = '{1'b0, 1'b0, 4'h1, 4'h0,  9, 12'h24F, 4'hE, 2'd1};
        vecs[11] = '{1'b0, 1'b0, 4'h1, 4'h0, 12, 12'h007, 4'hE, 2'd2};
        // drain[3] joins decay at tick 4, then clamps at 0
        vecs[12] = '{1'b1, 1'b0, 4'h0, 4'h0,  3, 12'h6DB, 4'h0, 2'd0};
        vecs[13] = '{1'b0, 1'b0, 4'h0, 4'h8,  4, 12'h292, 4'h8, 2'd1};
        vecs[14] = '{1'b0, 1'b0, 4'h0, 4'h8,  5, 12'h092, 4'h8, 2'd2};

        rst = 1'b1; acc = 1'b0; raise = '0; drain = '0;
        repeat (2) @(negedge clk);
        check("rst_level", level, 12'h6DB);
        check("rst_low",   low,   4'h0);
        check("rst_state", state, 2'd0);
        check("rst_tick",  tick,  1'b0);
        rst = 1'b0;
        ntick = 0;

        // Prescaler period, acc rising above limit, accelerated period
        wait_tick(cyc);
        wait_tick(cyc);
        check("tick_period_norm", cyc, 10);
        repeat (5) step();
        check("acc_pre_tick", tick, 1'b0);
        acc = 1'b1;
        step();
        check("acc_rise_tick", tick, 1'b1);
        wait_tick(cyc);
        check("tick_period_acc", cyc, 2);
        acc = 1'b0;

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            if (v.do_rst) begin
                do_reset(v.acc, v.raise, v.drain);
            end else begin
                acc = v.acc; raise = v.raise; drain = v.drain;
            end
            exp_q.push_back(v);
            run_to_tick(v.tgt);
            e = exp_q.pop_front();
            check($sformatf("vec%0d_level", i), level, e.lvl);
            check($sformatf("vec%0d_low", i),   low,   e.low);
            check($sformatf("vec%0d_state", i), state, e.st);
        end

        // One-cycle raise pulse: two-edge latency and decay counter restart
        do_reset(1'b0, 4'h0, 4'h0);
        run_to_tick(2);
        raise = 4'h1;
        step();
        raise = 4'h0;
        check("pulse_pending", level, 12'h6DB);
        step();
        check("pulse_level", level, 12'h6DC);
        run_to_tick(4);
        check("pulse_t4", level, 12'h494);
        run_to_tick(6);
        check("pulse_t6", level, 12'h493);

        // Raise increment landing on the same edge as a decay decrement
        do_reset(1'b0, 4'h0, 4'h0);
        run_to_tick(3);
        repeat (7) step();
        raise = 4'h2;
        step();
        check("coincide_tick", tick, 1'b1);
        raise = 4'h0;
        step();
        check("coincide_level", level, 12'h49A);
        run_to_tick(7);
        check("coincide_t7", level, 12'h49A);
        run_to_tick(8);
        check("coincide_t8", level, 12'h251);

        // CRITICAL recovery clears grace, then DEAD, raise ignored, async reset
        do_reset(1'b0, 4'h0, 4'h4);
        run_to_tick(6);
        check("crit_level", level, 12'h412);
        check("crit_state", state, 2'd2);
        drain = 4'h0;
        raise = 4'h4;
        step();
        raise = 4'h0;
        step();
        step();
        check("recover_level", level, 12'h452);
        check("recover_state", state, 2'd1);
        run_to_tick(17);
        check("grace_t17_state", state, 2'd2);
        run_to_tick(18);
        check("grace_t18_state", state, 2'd3);
        check("dead_level", level, 12'h000);
        raise = 4'h1;
        step();
        raise = 4'h0;
        repeat (3) step();
        check("dead_raise_level", level, 12'h000);
        check("dead_raise_state", state, 2'd3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_level", level, 12'h6DB);
        check("async_rst_state", state, 2'd0);
        check("async_rst_low",   low,   4'h0);
        check("async_rst_tick",  tick,  1'b0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pet_needs_engine.md
Name: pet_needs_engine

Overview:
Parametrised successor to the pet need-level controller. Tracks NCH independent need levels (hunger, sleep, fun, energy, ...), each LVL_W bits wide. Levels decay on a prescaled time base, rise on user raise requests with auto-repeat while held, and drain faster under per-channel drain inputs. An accelerate mode shortens the time base. A wellbeing FSM summarises all channels for the display/sprite logic downstream.

Parameters:
NCH, 4, number of need channels
LVL_W, 3, level width; MAXL = 2^LVL_W-1
INIT_LVL, 3, level loaded on reset (must be <= MAXL)
TICK_DIV, 100, clk cycles per base tick in normal mode (>=2)
ACC_DIV, 10, tick-rate multiplier in accelerate mode (TICK_DIV/ACC_DIV >= 1)
DECAY_TICKS, 20, ticks between natural decrements per channel
REPEAT_TICKS, 5, ticks between auto-repeat increments while raise is held
DRAIN_TICKS, 2, ticks between extra decrements while drain is held
LOW_TH, 1, level <= LOW_TH counts as low
GRACE_TICKS, 50, ticks in CRITICAL before DEAD

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
acc  in  1  accelerate mode (level-sensitive)
raise  in  NCH  per-channel raise request, synchronous and debounced upstream
drain  in  NCH  per-channel drain request (level-sensitive)
level  out  NCH*LVL_W  packed levels, channel i at [i*LVL_W +: LVL_W]
low  out  NCH  level[i] <= LOW_TH
state  out  2  00 HEALTHY, 01 NEEDY, 10 CRITICAL, 11 DEAD
tick  out  1  one-cycle base-tick strobe

Behaviour:
- Reset (async, rst=1): level[i]=INIT_LVL; all counters 0; raise edge register 0; state derived from INIT_LVL (HEALTHY if INIT_LVL>LOW_TH, otherwise NEEDY; CRITICAL if INIT_LVL=0); tick=0.
- Prescaler: limit = TICK_DIV-1 (acc=0) or TICK_DIV/ACC_DIV-1 (acc=1). tick=1 in the cycle after the counter reaches >= limit; counter then returns to 0. If acc rises while counter > new limit, tick fires on the next cycle.
- Decay: per-channel counter advances on tick. When it reaches DECAY_TICKS-1 on a tick, dec_decay=1 and the counter clears. Any accepted raise also clears it.
- Raise: a rising edge of raise[i] gives inc=1 on the next clk edge; the level updates 1 cycle after the edge sample. While held, a repeat counter advances on tick and gives inc=1 every REPEAT_TICKS ticks. Release clears the repeat counter.
- Drain: while drain[i]=1, a counter advances on tick and gives dec_drain=1 every DRAIN_TICKS ticks. It clears when drain deasserts.
- Update: next = level + inc - dec_decay - dec_drain, evaluated signed, clamped to [0, MAXL]. Simultaneous events net out: inc+decay leaves the level unchanged, and the decay counter still clears.
- Saturation: inc at MAXL holds MAXL; decrements at 0 hold 0. No wrap-around.
- FSM, evaluated every cycle on the registered levels:
  - HEALTHY -> NEEDY if any low.
  - NEEDY -> HEALTHY if none low; NEEDY -> CRITICAL if any level = 0.
  - CRITICAL -> NEEDY if no level = 0. Otherwise the grace counter counts ticks and goes to DEAD at GRACE_TICKS. The grace counter clears whenever CRITICAL is left.
  - DEAD is absorbing until rst. In DEAD, raise is ignored, decay and drain continue, and levels reach 0 and hold.
- Reset mid-operation: all state is lost immediately; no pending increment survives.

Test Plan (TICK_DIV=10, ACC_DIV=5, DECAY_TICKS=4, REPEAT_TICKS=3, DRAIN_TICKS=1, INIT_LVL=3, LVL_W=3, LOW_TH=1, GRACE_TICKS=8):
1. Release rst, no inputs -> tick every 10 cycles; every channel goes 3->2 at tick 4, ->1 at tick 8 (low=4'hF, state=NEEDY), ->0 at tick 12 (CRITICAL), DEAD at tick 20.
2. acc=1 from reset -> tick every 2 cycles; channel levels reach 0 after 24 cycles of ticks (12 ticks).
3. raise[0] pulsed 1 cycle at level 3 -> level0=4 two edges later, decay counter 0 cleared; held 9 ticks -> 4,5,6,7 then holds 7 (saturation).
4. drain[3]=1 with level3=3 -> decrements every tick plus decay coincidence at tick 4 (-2 net); level3 clamps at 0 and state=CRITICAL.
5. raise[1] edge on the same cycle as a decay decrement -> level1 unchanged; next decay 4 ticks later.
6. Reach CRITICAL, raise the zero channel before 8 ticks -> state NEEDY, grace cleared. Then reach DEAD, apply raise -> no change; assert rst mid-DEAD -> levels 3, state HEALTHY immediately.
